update_bin_writer: RTL and testbench

- Downstream of the scatter multiply stage. Consumes its stream of (update_value, update_dest, valid).
- Sorts each update into one of NUM_BINS destination-interval bins, each with its own small circular buffer.
- Emits fixed-length bursts of {dest, value} to the off-chip update writer over a valid/ready interface.
- Stalls the edge feed when any bin nears full. Drains partial bins on flush at end of a scatter phase.

---
 rtl/update_bin_writer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_update_bin_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/update_bin_writer.sv
// update_bin_writer
//   Sorts the update stream from the scatter multiply stage into NUM_BINS
//   destination-interval bins. Each bin has its own circular buffer. Full
//   bins are drained as fixed-length bursts of {dest, value} to the
//   off-chip update writer. Partial bins are drained when a flush is
//   requested.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   update_value      32-bit value from the scatter stage
//   update_dest       32-bit destination vertex id (selects the bin)
//   update_valid      update present this cycle (no backpressure)
//   flush             single-cycle pulse: drain every bin
//   stall             registered request to stop the edge feed
//   out_data          {dest, value} beat
//   out_bin           bin that the current burst comes from
//   out_valid         beat valid
//   out_ready         downstream accepts the beat
//   out_last          final beat of the burst
//   flush_done        one-cycle pulse: flush finished, all bins empty
//   overflow          sticky: an update was dropped because its bin was full
module update_bin_writer #(
   parameter int NUM_BINS  = 4,
   parameter int BIN_SHIFT = 16,
   parameter int BUF_DEPTH = 16,
   parameter int BURST_LEN = 8,
   parameter int AF_MARGIN = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 update_value,
   input  logic [31:0]                 update_dest,
   input  logic                        update_valid,
   input  logic                        flush,
   output logic                        stall,
   output logic [63:0]                 out_data,
   output logic [$clog2(NUM_BINS)-1:0] out_bin,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        flush_done,
   output logic                        overflow
);

   localparam int BIN_W = $clog2(NUM_BINS);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [BIN_W-1:0] BIN_ONE   = BIN_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] CNT_BURST = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(BUF_DEPTH - AF_MARGIN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state_r;
   state_t state_nx;

   // Per-bin circular buffers and bookkeeping
   logic [63:0]      mem_r   [NUM_BINS][BUF_DEPTH];
   logic [CNT_W-1:0] count_r [NUM_BINS];
   logic [PTR_W-1:0] head_r  [NUM_BINS];
   logic [PTR_W-1:0] tail_r  [NUM_BINS];
   logic [CNT_W-1:0] count_nx_s [NUM_BINS];

   logic [NUM_BINS-1:0] wr_s;
   logic [NUM_BINS-1:0] rd_s;
   logic [BIN_W-1:0]    in_bin_s;
   logic                drop_s;
   logic                stall_nx_s;
   logic                pop_s;

   // Arbitration
   logic [BIN_W-1:0] rr_r;
   logic [BIN_W-1:0] rr_nx_s;
   logic [BIN_W-1:0] cand_s;
   logic             full_found_s;
   logic [BIN_W-1:0] full_sel_s;
   logic             any_ne_s;
   logic [BIN_W-1:0] low_sel_s;
   logic             start_s;
   logic [BIN_W-1:0] start_sel_s;
   logic [CNT_W-1:0] start_len_s;

   // Burst tracking
   logic [CNT_W-1:0] beat_r;
   logic [CNT_W-1:0] len_r;
   logic             flush_pending_r;

   assign in_bin_s = update_dest[BIN_SHIFT +: BIN_W];
   assign pop_s    = out_valid & out_ready;
   assign drop_s   = update_valid & (count_r[in_bin_s] == CNT_FULL);

   // Per-bin write/read strobes, next-state counts and the stall condition
   always_comb begin
      stall_nx_s = 1'b0;
      for (int b = 0; b < NUM_BINS; b++) begin
         wr_s[b] = update_valid & (in_bin_s == BIN_W'(b)) & (count_r[b] != CNT_FULL);
         rd_s[b] = pop_s & (out_bin == BIN_W'(b));
         // A simultaneous write and read leaves the count unchanged
         case ({wr_s[b], rd_s[b]})
            2'b10:   count_nx_s[b] = count_r[b] + CNT_ONE;
            2'b01:   count_nx_s[b] = count_r[b] - CNT_ONE;
            default: count_nx_s[b] = count_r[b];
         endcase
         if (count_nx_s[b] >= CNT_AF) begin
            stall_nx_s = 1'b1;
         end else begin
            stall_nx_s = stall_nx_s;
         end
      end
   end

   // Bin selection: round-robin among full bins, lowest index among non-empty bins
   always_comb begin
      full_found_s = 1'b0;
      full_sel_s   = {BIN_W{1'b0}};
      cand_s       = {BIN_W{1'b0}};
      any_ne_s     = 1'b0;
      low_sel_s    = {BIN_W{1'b0}};
      for (int i = 0; i < NUM_BINS; i++) begin
         cand_s = rr_r + BIN_W'(i);
         if (!full_found_s && (count_r[cand_s] >= CNT_BURST)) begin
            full_found_s = 1'b1;
            full_sel_s   = cand_s;
         end else begin
            full_found_s = full_found_s;
         end
      end
      // Descending scan so the lowest non-empty index is the one kept
      for (int i = NUM_BINS - 1; i >= 0; i--) begin
         if (count_r[i] != {CNT_W{1'b0}}) begin
            any_ne_s  = 1'b1;
            low_sel_s = BIN_W'(i);
         end else begin
            any_ne_s  = any_ne_s;
         end
      end
   end

   // FSM next-state and burst launch decision
   always_comb begin
      state_nx    = state_r;
      start_s     = 1'b0;
      start_sel_s = {BIN_W{1'b0}};
      start_len_s = {CNT_W{1'b0}};
      rr_nx_s     = rr_r;
      case (state_r)
         IDLE: begin
            if (full_found_s) begin
               start_s     = 1'b1;
               start_sel_s = full_sel_s;
               start_len_s = CNT_BURST;
               rr_nx_s     = full_sel_s + BIN_ONE;
               state_nx    = BURST;
            end else if (flush_pending_r && any_ne_s) begin
               // Partial drain: the snapshot is below BURST_LEN here
               start_s     = 1'b1;
               start_sel_s = low_sel_s;
               start_len_s = count_r[low_sel_s];
               state_nx    = BURST;
            end else if (flush_pending_r) begin
               state_nx    = DONE;
            end else begin
               state_nx    = IDLE;
            end
         end
         BURST: begin
            if (pop_s && out_last) begin
               state_nx = IDLE;
            end else begin
               state_nx = BURST;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Bin counts and head/tail pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NUM_BINS; b++) begin
            count_r[b] <= {CNT_W{1'b0}};
            head_r[b]  <= {PTR_W{1'b0}};
            tail_r[b]  <= {PTR_W{1'b0}};
         end
      end else begin
         for (int b = 0; b < NUM_BINS; b++) begin
            count_r[b] <= count_nx_s[b];
            if (wr_s[b]) begin
               tail_r[b] <= tail_r[b] + PTR_ONE;
            end
            if (rd_s[b]) begin
               head_r[b] <= head_r[b] + PTR_ONE;
            end
         end
      end
   end

   // Buffer storage; contents are only meaningful below the count, so no reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BINS; b++) begin
         if (wr_s[b]) begin
            mem_r[b][tail_r[b]] <= {update_dest, update_value};
         end
      end
   end

   // Output beat registers, round-robin pointer, flush and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_last        <= 1'b0;
         out_data        <= 64'd0;
         out_bin         <= {BIN_W{1'b0}};
         beat_r          <= {CNT_W{1'b0}};
         len_r           <= {CNT_W{1'b0}};
         rr_r            <= {BIN_W{1'b0}};
         flush_pending_r <= 1'b0;
         flush_done      <= 1'b0;
         overflow        <= 1'b0;
         stall           <= 1'b0;
      end else begin
         if (start_s) begin
            out_valid <= 1'b1;
            out_data  <= mem_r[start_sel_s][head_r[start_sel_s]];
            out_bin   <= start_sel_s;
            out_last  <= (start_len_s == CNT_ONE);
            beat_r    <= CNT_ONE;
            len_r     <= start_len_s;
         end else if (pop_s) begin
            if (out_last) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end else begin
               // Head advances on this edge, so present the entry behind it
               out_data <= mem_r[out_bin][head_r[out_bin] + PTR_ONE];
               out_last <= ((beat_r + CNT_ONE) == len_r);
               beat_r   <= beat_r + CNT_ONE;
            end
         end
         rr_r <= rr_nx_s;
         if (state_r == DONE) begin
            flush_pending_r <= flush;
         end else if (flush) begin
            flush_pending_r <= 1'b1;
         end
         flush_done <= (state_nx == DONE);
         overflow   <= overflow | drop_s;
         stall      <= stall_nx_s;
      end
   end

endmodule

// File: tb/tb_update_bin_writer.sv
// tb_update_bin_writer
//   Scoreboarded bench for update_bin_writer. Every update written is pushed
//   onto a per-bin expected queue; every accepted output beat is popped and
//   compared. Burst order and lengths are logged and checked per scenario.
module tb_update_bin_writer;

   localparam int NUM_BINS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] update_value;
   logic [31:0] update_dest;
   logic        update_valid;
   logic        flush;
   logic        stall;
   logic [63:0] out_data;
   logic [1:0]  out_bin;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        flush_done;
   logic        overflow;

   always #5 clk = ~clk;

   update_bin_writer #(
      .NUM_BINS (4),
      .BIN_SHIFT(16),
      .BUF_DEPTH(16),
      .BURST_LEN(8),
      .AF_MARGIN(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .update_value(update_value),
      .update_dest (update_dest),
      .update_valid(update_valid),
      .flush       (flush),
      .stall       (stall),
      .out_data    (out_data),
      .out_bin     (out_bin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .flush_done  (flush_done),
      .overflow    (overflow)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] mdl_q [NUM_BINS][$];
   int          burst_bins[$];
   int          burst_lens[$];
   int          fd_cnt   = 0;
   int          beat_idx = 0;
   bit          prev_go  = 1'b0;
   int          mon_bin;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard compare, burst logging, bubble detection
   always @(negedge clk) begin
      if (rst) begin
         beat_idx = 0;
         prev_go  = 1'b0;
      end else begin
         if (prev_go) check_eq("no_bubble", 64'(out_valid), 64'd1);
         prev_go = 1'b0;
         if (flush_done) fd_cnt++;
         if (out_valid) begin
            mon_bin = int'(out_bin);
            check_eq("beat_avail", 64'(mdl_q[mon_bin].size() != 0), 64'd1);
            if (mdl_q[mon_bin].size() != 0) begin
               check_eq("beat_data", out_data, mdl_q[mon_bin][0]);
               if (out_ready) begin
                  void'(mdl_q[mon_bin].pop_front());
                  beat_idx++;
                  if (out_last) begin
                     burst_bins.push_back(mon_bin);
                     burst_lens.push_back(beat_idx);
                     beat_idx = 0;
                  end else begin
                     prev_go = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] dest, input logic [31:0] val, input bit keep);
      logic [1:0] b;
      b = dest[17:16];
      update_dest  = dest;
      update_value = val;
      update_valid = 1'b1;
      if (keep) mdl_q[b].push_back({dest, val});
      @(posedge clk);
      #1;
      update_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic drain(input string tag);
      int cyc;
      bit empty;
      cyc   = 0;
      empty = 1'b0;
      while (!empty && cyc < 400) begin
         @(negedge clk);
         cyc++;
         empty = !out_valid && (mdl_q[0].size() == 0) && (mdl_q[1].size() == 0) &&
                 (mdl_q[2].size() == 0) && (mdl_q[3].size() == 0);
      end
      check_eq({tag, "_drained"}, 64'(empty), 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
   endtask

   task automatic wait_flush_done(input string tag);
      int cyc;
      cyc = 0;
      while (fd_cnt == 0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq({tag, "_flush_done_seen"}, 64'(fd_cnt != 0), 64'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_bursts(input string tag, input int n, input int eb [4], input int el [4]);
      check_eq({tag, "_nbursts"}, 64'(burst_bins.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < burst_bins.size()) begin
            check_eq({tag, "_burst_bin"}, 64'(burst_bins[i]), 64'(eb[i]));
            check_eq({tag, "_burst_len"}, 64'(burst_lens[i]), 64'(el[i]));
         end
      end
      burst_bins.delete();
      burst_lens.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      update_value = 32'd0;
      update_dest  = 32'd0;
      update_valid = 1'b0;
      flush        = 1'b0;
      out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid",  64'(out_valid),  64'd0);
      check_eq("rst_out_last",   64'(out_last),   64'd0);
      check_eq("rst_stall",      64'(stall),      64'd0);
      check_eq("rst_flush_done", 64'(flush_done), 64'd0);
      check_eq("rst_overflow",   64'(overflow),   64'd0);
      check_eq("rst_out_data",   out_data,        64'd0);
      check_eq("rst_out_bin",    64'(out_bin),    64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single full burst on bin 0 with latency check
      for (int i = 0; i < 8; i++) send(32'(i), 32'(i + 1), 1'b1);
      check_eq("t1_lat_t1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check_eq("t1_lat_t2", 64'(out_valid), 64'd1);
      check_eq("t1_first_data", out_data, {32'h0, 32'h1});
      check_eq("t1_first_last", 64'(out_last), 64'd0);
      drain("t1");
      check_bursts("t1", 1, '{0, 0, 0, 0}, '{8, 0, 0, 0});

      // Interleaved bins 1 and 2
      for (int i = 0; i < 8; i++) begin
         send(32'h0001_0000 + 32'(i), 32'h100 + 32'(i), 1'b1);
         send(32'h0002_0000 + 32'(i), 32'h200 + 32'(i), 1'b1);
      end
      drain("t2");
      check_bursts("t2", 2, '{1, 2, 0, 0}, '{8, 8, 0, 0});

      // Round-robin: bin 1 busy, then bins 0 and 3 full; rr starts at 2 so 3 precedes 0
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(32'h0001_0010 + 32'(i), 32'h300 + 32'(i), 1'b1);
      for (int i = 0; i < 8; i++) begin
         send(32'h0000_0100 + 32'(i), 32'h400 + 32'(i), 1'b1);
         send(32'h0003_0000 + 32'(i), 32'h500 + 32'(i), 1'b1);
      end
      out_ready = 1'b1;
      drain("t2b");
      check_bursts("t2b", 3, '{1, 3, 0, 0}, '{8, 8, 8, 0});

      // Flush of a partial bin
      fd_cnt = 0;
      for (int i = 0; i < 3; i++) send(32'h0003_0100 + 32'(i), 32'h600 + 32'(i), 1'b1);
      pulse_flush();
      wait_flush_done("t3");
      drain("t3");
      check_bursts("t3", 1, '{3, 0, 0, 0}, '{3, 0, 0, 0});
      check_eq("t3_flush_done_once", 64'(fd_cnt), 64'd1);

      // Backpressure mid-burst
      for (int i = 0; i < 8; i++) send(32'h0000_0200 + 32'(i), 32'h700 + 32'(i), 1'b1);
      wait_valid("t4");
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("t4");
      check_bursts("t4", 1, '{0, 0, 0, 0}, '{8, 0, 0, 0});

      // Stall threshold and overflow
      out_ready = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         send(32'h0001_0000 + 32'(k), 32'(k), (k <= 16));
         if (k <= 16) check_eq("t5_stall", 64'(stall), 64'(k >= 12));
         check_eq("t5_overflow", 64'(overflow), 64'(k == 17));
      end
      out_ready = 1'b1;
      drain("t5");
      check_bursts("t5", 2, '{1, 1, 0, 0}, '{8, 8, 0, 0});
      check_eq("t5_overflow_sticky", 64'(overflow), 64'd1);
      check_eq("t5_stall_clear", 64'(stall), 64'd0);

      // Reset mid-burst
      for (int i = 0; i < 8; i++) send(32'h0002_0300 + 32'(i), 32'h800 + 32'(i), 1'b1);
      wait_valid("t6");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("t6_out_valid", 64'(out_valid), 64'd0);
      check_eq("t6_stall",     64'(stall),     64'd0);
      check_eq("t6_overflow",  64'(overflow),  64'd0);
      check_eq("t6_out_last",  64'(out_last),  64'd0);
      check_eq("t6_out_data",  out_data,       64'd0);
      for (int b = 0; b < NUM_BINS; b++) mdl_q[b].delete();
      burst_bins.delete();
      burst_lens.delete();
      rst    = 1'b0;
      fd_cnt = 0;
      @(posedge clk);
      #1;
      pulse_flush();
      wait_flush_done("t6");
      check_bursts("t6", 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});
      check_eq("t6_flush_done_once", 64'(fd_cnt), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
